// File: rtl/serial_pkg.sv
// Shared definitions for the serial word stream: transmitter states, residue type and bit order.
// The receive-side detectors import this package too.
package serial_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam int unsigned Mod4 = 4;

  typedef logic [$clog2(Mod4)-1:0] residue_t;

  // Words go out most-significant bit first.
  localparam bit MsbFirst = 1'b1;

endpackage

// File: rtl/mod4_tracker.sv
// Running residue (mod 4) of an MSB-first bit stream, with a registered "prefix divisible" flag.
// Shared with the receive-side checkers.
module mod4_tracker
  import serial_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     bit_valid,
  input  logic     bit_in,
  output residue_t residue,
  output logic     div4
);

  residue_t base;
  residue_t r_next;

  // A clear coinciding with a bit starts the new word from residue 0.
  always_comb begin
    base   = clear ? '0 : residue;
    r_next = residue_t'((2 * base + bit_in) % Mod4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      residue <= '0;
      div4    <= 1'b0;
    end else begin
      if (bit_valid) begin
        residue <= r_next;
      end else if (clear) begin
        residue <= '0;
      end
      div4 <= bit_valid && (r_next == '0);
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter with framing, last-bit marker, done pulse and a golden
// prefix-divisible-by-4 flag for the serial divisibility detectors.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             div4,
  output logic             done
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam int unsigned     GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam int unsigned     OutIdx  = MsbFirst ? WIDTH - 1 : 0;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic [GapW-1:0]  gap_q;
  logic             last_bit;
  logic             accept;
  logic             bit_valid;
  logic             next_bit;
  residue_t         unused_residue;

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MsbFirst ? (w << 1) : (w >> 1);
  endfunction

  // shreg_q holds the bits not yet on the wire, so next_bit is what the coming edge presents.
  always_comb begin
    last_bit   = (state_q == StShift) && (cnt_q == LastCnt);
    load_ready = (state_q == StIdle) || ((GAP_CYCLES == 0) && last_bit);
    accept     = load_valid && load_ready;
    bit_valid  = accept || ((state_q == StShift) && !last_bit);
    next_bit   = accept ? data_in[OutIdx] : shreg_q[OutIdx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_bit;
      if (accept) begin
        state_q   <= StShift;
        shreg_q   <= advance(data_in);
        cnt_q     <= '0;
        out       <= next_bit;
        out_valid <= 1'b1;
        last      <= 1'b0;
      end else begin
        case (state_q)
          StShift: begin
            if (last_bit) begin
              state_q   <= (GAP_CYCLES > 0) ? StGap : StIdle;
              gap_q     <= '0;
              out       <= 1'b0;
              out_valid <= 1'b0;
              last      <= 1'b0;
            end else begin
              shreg_q <= advance(shreg_q);
              cnt_q   <= cnt_q + 1'b1;
              out     <= next_bit;
              last    <= (cnt_q + 1'b1 == LastCnt);
            end
          end
          StGap: begin
            if (gap_q == GapLast) begin
              state_q <= StIdle;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          StIdle:  ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  mod4_tracker u_mod4 (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .bit_valid (bit_valid),
    .bit_in    (next_bit),
    .residue   (unused_residue),
    .div4      (div4)
  );

endmodule
